// File: rtl/io_turnaround_pkg.sv
// Shared types and constants for the bidirectional pad direction sequencer.
package io_turnaround_pkg;

    // Debug-visible state encodings driven onto STATE.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TX        = 3'd1,
        ST_RX_SETTLE = 3'd2,
        ST_RX        = 3'd3,
        ST_TURN      = 3'd4
    } state_e;

    // Which side last held the pad, used for round-robin ties.
    typedef enum logic {
        SIDE_TX = 1'b0,
        SIDE_RX = 1'b1
    } side_e;

    // Side owed the next tie after a forced release.
    typedef enum logic [1:0] {
        PRE_NONE = 2'd0,
        PRE_TX   = 2'd1,
        PRE_RX   = 2'd2
    } preempt_e;

    // Simultaneous-request policy names.
    localparam string PRIO_TX = "TX";
    localparam string PRIO_RX = "RX";
    localparam string PRIO_RR = "RR";

    // Guard/settle timer and hold counter widths.
    localparam int GUARD_W = 4;
    localparam int HOLD_W  = 8;

    // Timer reload for an interval of 'cycles' cycles (done flag is count == 0).
    function automatic logic [GUARD_W-1:0] guard_load(input int unsigned cycles);
        return (cycles == 0) ? '0 : GUARD_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/io_guard_timer.sv
// Loadable 4-bit down-counter with done flag; shared by TURN and RX_SETTLE.
module io_guard_timer
    import io_turnaround_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [GUARD_W-1:0] load_val,
    input  logic               en,
    output logic               done
);

    logic [GUARD_W-1:0] cnt_q;
    logic [GUARD_W-1:0] cnt_d;

    // Load takes priority; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/io_turnaround_ctrl.sv
// Direction sequencer for one shared O_BUFT/I_BUF pad: arbitrates TX/RX
// requesters, enforces a guard interval between driver and receiver, and
// registers all buffer controls and grants.
module io_turnaround_ctrl
    import io_turnaround_pkg::*;
#(
    parameter int unsigned TURN_CYCLES      = 2,
    parameter int unsigned RX_SETTLE_CYCLES = 1,
    parameter string       PRIORITY         = "RR",
    parameter int unsigned MAX_HOLD         = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TX_REQ,
    input  logic       RX_REQ,
    output logic       TX_GNT,
    output logic       RX_GNT,
    output logic       OBUF_T,
    output logic       IBUF_EN,
    output logic       BUSY,
    output logic [2:0] STATE
);

    localparam logic [GUARD_W-1:0] TURN_LOAD   = guard_load(TURN_CYCLES);
    localparam logic [GUARD_W-1:0] SETTLE_LOAD = guard_load(RX_SETTLE_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LIMIT  = HOLD_W'(MAX_HOLD);
    localparam bit                 HOLD_EN     = (MAX_HOLD != 0);
    localparam bit                 FIXED_TX    = (PRIORITY == PRIO_TX);
    localparam bit                 FIXED_RX    = (PRIORITY == PRIO_RX);
    localparam state_e             RELEASE_ST  = (TURN_CYCLES == 0) ? ST_IDLE : ST_TURN;

    state_e              state_q, state_d;
    side_e               rr_last_q, rr_last_d;
    preempt_e            preempt_q, preempt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
    logic                tie_tx;
    logic                timer_load;
    logic [GUARD_W-1:0]  timer_load_val;
    logic                timer_en;
    logic                timer_done;

    logic obuf_t_q, obuf_t_d;
    logic tx_gnt_q, tx_gnt_d;
    logic ibuf_en_q, ibuf_en_d;
    logic rx_gnt_q, rx_gnt_d;
    logic busy_q, busy_d;
    logic [2:0] state_o_q, state_o_d;

    io_guard_timer u_guard_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .done     (timer_done)
    );

    assign timer_en = (state_q == ST_TURN) || (state_q == ST_RX_SETTLE);

    // Saturating increment; the forced-release compare uses the count that
    // includes the current cycle so the grant lasts exactly MAX_HOLD cycles.
    assign hold_inc = (hold_q == '1) ? hold_q : hold_q + 1'b1;

    // Tie winner when both requests are high in IDLE: preempt flag, then policy.
    always_comb begin
        tie_tx = (rr_last_q == SIDE_RX);
        if (FIXED_TX) begin
            tie_tx = 1'b1;
        end else if (FIXED_RX) begin
            tie_tx = 1'b0;
        end
        if (preempt_q == PRE_TX) begin
            tie_tx = 1'b1;
        end else if (preempt_q == PRE_RX) begin
            tie_tx = 1'b0;
        end
    end

    // Next-state, arbitration, hold counting and guard timer loading.
    always_comb begin
        state_d        = state_q;
        rr_last_d      = rr_last_q;
        preempt_d      = preempt_q;
        hold_d         = '0;
        timer_load     = 1'b0;
        timer_load_val = TURN_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (TX_REQ || RX_REQ) begin
                    preempt_d = PRE_NONE;
                    if (TX_REQ && (!RX_REQ || tie_tx)) begin
                        state_d = ST_TX;
                    end else if (RX_SETTLE_CYCLES == 0) begin
                        state_d = ST_RX;
                    end else begin
                        state_d        = ST_RX_SETTLE;
                        timer_load     = 1'b1;
                        timer_load_val = SETTLE_LOAD;
                    end
                end
            end
            ST_TX: begin
                rr_last_d = SIDE_TX;
                hold_d    = RX_REQ ? hold_inc : hold_q;
                if (!TX_REQ) begin
                    state_d    = RELEASE_ST;
                    timer_load = (RELEASE_ST == ST_TURN);
                    hold_d     = '0;
                end else if (HOLD_EN && RX_REQ && (hold_inc == HOLD_LIMIT)) begin
                    state_d    = RELEASE_ST;
                    timer_load = (RELEASE_ST == ST_TURN);
                    hold_d     = '0;
                    preempt_d  = PRE_RX;
                end
            end
            ST_RX_SETTLE: begin
                if (!RX_REQ) begin
                    state_d    = RELEASE_ST;
                    timer_load = (RELEASE_ST == ST_TURN);
                end else if (timer_done) begin
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                rr_last_d = SIDE_RX;
                hold_d    = TX_REQ ? hold_inc : hold_q;
                if (!RX_REQ) begin
                    state_d    = RELEASE_ST;
                    timer_load = (RELEASE_ST == ST_TURN);
                    hold_d     = '0;
                end else if (HOLD_EN && TX_REQ && (hold_inc == HOLD_LIMIT)) begin
                    state_d    = RELEASE_ST;
                    timer_load = (RELEASE_ST == ST_TURN);
                    hold_d     = '0;
                    preempt_d  = PRE_TX;
                end
            end
            ST_TURN: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode of the next state, so the flops hold a decode of the state register.
    always_comb begin
        obuf_t_d  = (state_d == ST_TX);
        tx_gnt_d  = (state_d == ST_TX);
        ibuf_en_d = (state_d == ST_RX_SETTLE) || (state_d == ST_RX);
        rx_gnt_d  = (state_d == ST_RX);
        busy_d    = (state_d != ST_IDLE);
        state_o_d = state_d;
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            rr_last_q <= SIDE_RX;
            preempt_q <= PRE_NONE;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
        end
    end

    // Registered outputs; all clear asynchronously on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            obuf_t_q  <= 1'b0;
            tx_gnt_q  <= 1'b0;
            ibuf_en_q <= 1'b0;
            rx_gnt_q  <= 1'b0;
            busy_q    <= 1'b0;
            state_o_q <= '0;
        end else begin
            obuf_t_q  <= obuf_t_d;
            tx_gnt_q  <= tx_gnt_d;
            ibuf_en_q <= ibuf_en_d;
            rx_gnt_q  <= rx_gnt_d;
            busy_q    <= busy_d;
            state_o_q <= state_o_d;
        end
    end

    assign OBUF_T  = obuf_t_q;
    assign TX_GNT  = tx_gnt_q;
    assign IBUF_EN = ibuf_en_q;
    assign RX_GNT  = rx_gnt_q;
    assign BUSY    = busy_q;
    assign STATE   = state_o_q;

endmodule

// File: tb/tb_io_turnaround_ctrl.sv
// Directed bench for io_turnaround_ctrl: four instances with different
// guard/priority/hold settings, driven one at a time from a single sequence.
module tb_io_turnaround_ctrl;

    // Output vector layout: {BUSY, TX_GNT, OBUF_T, RX_GNT, IBUF_EN, STATE[2:0]}
    localparam logic [7:0] V_IDLE = 8'h00;
    localparam logic [7:0] V_TX   = 8'hE1;
    localparam logic [7:0] V_SET  = 8'h8A;
    localparam logic [7:0] V_RX   = 8'h9B;
    localparam logic [7:0] V_TURN = 8'h84;

    localparam int TURN_P [4] = '{2, 2, 2, 0};

    logic       clk;
    logic       rst_n;
    logic       tx_r [4];
    logic       rx_r [4];
    logic [7:0] dut_o [4];

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    int   last_ob_fall [4];
    int   last_ie_fall [4];
    logic prev_ob [4];
    logic prev_ie [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // A: RR, 2 turn, 1 settle, unlimited hold
    io_turnaround_ctrl #(.TURN_CYCLES(2), .RX_SETTLE_CYCLES(1), .PRIORITY("RR"), .MAX_HOLD(0)) u_a (
        .CLK(clk), .RST_N(rst_n), .TX_REQ(tx_r[0]), .RX_REQ(rx_r[0]),
        .TX_GNT(dut_o[0][6]), .RX_GNT(dut_o[0][4]), .OBUF_T(dut_o[0][5]),
        .IBUF_EN(dut_o[0][3]), .BUSY(dut_o[0][7]), .STATE(dut_o[0][2:0]));

    // B: fixed TX priority, hold limit 4
    io_turnaround_ctrl #(.TURN_CYCLES(2), .RX_SETTLE_CYCLES(1), .PRIORITY("TX"), .MAX_HOLD(4)) u_b (
        .CLK(clk), .RST_N(rst_n), .TX_REQ(tx_r[1]), .RX_REQ(rx_r[1]),
        .TX_GNT(dut_o[1][6]), .RX_GNT(dut_o[1][4]), .OBUF_T(dut_o[1][5]),
        .IBUF_EN(dut_o[1][3]), .BUSY(dut_o[1][7]), .STATE(dut_o[1][2:0]));

    // C: 3-cycle receiver settle
    io_turnaround_ctrl #(.TURN_CYCLES(2), .RX_SETTLE_CYCLES(3), .PRIORITY("RR"), .MAX_HOLD(0)) u_c (
        .CLK(clk), .RST_N(rst_n), .TX_REQ(tx_r[2]), .RX_REQ(rx_r[2]),
        .TX_GNT(dut_o[2][6]), .RX_GNT(dut_o[2][4]), .OBUF_T(dut_o[2][5]),
        .IBUF_EN(dut_o[2][3]), .BUSY(dut_o[2][7]), .STATE(dut_o[2][2:0]));

    // D: zero guard and zero settle
    io_turnaround_ctrl #(.TURN_CYCLES(0), .RX_SETTLE_CYCLES(0), .PRIORITY("RR"), .MAX_HOLD(0)) u_d (
        .CLK(clk), .RST_N(rst_n), .TX_REQ(tx_r[3]), .RX_REQ(rx_r[3]),
        .TX_GNT(dut_o[3][6]), .RX_GNT(dut_o[3][4]), .OBUF_T(dut_o[3][5]),
        .IBUF_EN(dut_o[3][3]), .BUSY(dut_o[3][7]), .STATE(dut_o[3][2:0]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic gap_chk(input string tag, input int gap, input int need);
        n_checks++;
        assert (gap >= need) else begin
            n_errors++;
            $error("FAIL %s: observed gap %0d cycles, required >= %0d", tag, gap, need);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-cycle invariants: exclusivity, grant implies buffer, guard gap.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    last_ob_fall[i] = -1;
                    last_ie_fall[i] = -1;
                    prev_ob[i]      = 1'b0;
                    prev_ie[i]      = 1'b0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("invariants_%0d", i),
                        {5'b0, dut_o[i][5] & dut_o[i][3], dut_o[i][6] & ~dut_o[i][5],
                         dut_o[i][4] & ~dut_o[i][3]}, 8'h00);
                    if (prev_ob[i] && !dut_o[i][5]) last_ob_fall[i] = cyc_cnt;
                    if (prev_ie[i] && !dut_o[i][3]) last_ie_fall[i] = cyc_cnt;
                    if (!prev_ie[i] && dut_o[i][3] && last_ob_fall[i] >= 0)
                        gap_chk($sformatf("gap_tx_to_rx_%0d", i), cyc_cnt - last_ob_fall[i], TURN_P[i] + 1);
                    if (!prev_ob[i] && dut_o[i][5] && last_ie_fall[i] >= 0)
                        gap_chk($sformatf("gap_rx_to_tx_%0d", i), cyc_cnt - last_ie_fall[i], TURN_P[i] + 1);
                    prev_ob[i] = dut_o[i][5];
                    prev_ie[i] = dut_o[i][3];
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_r[i] = 1'b0;
            rx_r[i] = 1'b0;
        end
        step(2);
        for (int i = 0; i < 4; i++) chk($sformatf("reset_%0d", i), dut_o[i], V_IDLE);
        rst_n = 1'b1;
        step(1); chk("a_idle", dut_o[0], V_IDLE);

        // A: TX for 5 cycles, then RX with guard and settle
        tx_r[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1); chk($sformatf("a_tx_gnt_%0d", k), dut_o[0], V_TX);
        end
        tx_r[0] = 1'b0; rx_r[0] = 1'b1;
        step(1); chk("a_turn0", dut_o[0], V_TURN);
        step(1); chk("a_turn1", dut_o[0], V_TURN);
        step(1); chk("a_idle_gap", dut_o[0], V_IDLE);
        step(1); chk("a_rx_settle", dut_o[0], V_SET);
        step(1); chk("a_rx_gnt", dut_o[0], V_RX);
        rx_r[0] = 1'b0;
        step(1); chk("a_rx_turn0", dut_o[0], V_TURN);
        step(1); chk("a_rx_turn1", dut_o[0], V_TURN);
        step(1); chk("a_rx_idle", dut_o[0], V_IDLE);

        // A: asynchronous reset in the middle of a TX grant
        tx_r[0] = 1'b1;
        step(1); chk("a_pre_reset_tx", dut_o[0], V_TX);
        #2 rst_n = 1'b0;
        #1 chk("a_async_reset", dut_o[0], V_IDLE);
        tx_r[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("a_post_reset", dut_o[0], V_IDLE);

        // A: round-robin ties, TX first after reset
        tx_r[0] = 1'b1; rx_r[0] = 1'b1;
        step(1); chk("a_rr_first_tx", dut_o[0], V_TX);
        step(1); chk("a_rr_first_tx_hold", dut_o[0], V_TX);
        tx_r[0] = 1'b0;
        step(1); chk("a_rr_turn0", dut_o[0], V_TURN);
        tx_r[0] = 1'b1;
        step(1); chk("a_rr_turn1", dut_o[0], V_TURN);
        step(1); chk("a_rr_idle", dut_o[0], V_IDLE);
        step(1); chk("a_rr_second_rx_settle", dut_o[0], V_SET);
        step(1); chk("a_rr_second_rx", dut_o[0], V_RX);
        rx_r[0] = 1'b0;
        step(1); chk("a_rr_turn2", dut_o[0], V_TURN);
        step(1); chk("a_rr_turn3", dut_o[0], V_TURN);
        step(1); chk("a_rr_idle2", dut_o[0], V_IDLE);
        step(1); chk("a_rr_third_tx", dut_o[0], V_TX);
        tx_r[0] = 1'b0;
        step(3); chk("a_rr_done", dut_o[0], V_IDLE);

        // B: forced release after 4 granted cycles, RX served via preempt
        tx_r[1] = 1'b1; rx_r[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1); chk($sformatf("b_hold_tx_%0d", k), dut_o[1], V_TX);
        end
        step(1); chk("b_forced_release", dut_o[1], V_TURN);
        step(1); chk("b_forced_turn1", dut_o[1], V_TURN);
        step(1); chk("b_forced_idle", dut_o[1], V_IDLE);
        step(1); chk("b_preempt_rx_settle", dut_o[1], V_SET);
        step(1); chk("b_preempt_rx", dut_o[1], V_RX);
        step(1); chk("b_rx_hold", dut_o[1], V_RX);
        rx_r[1] = 1'b0;
        step(1); chk("b_rx_turn0", dut_o[1], V_TURN);
        step(1); chk("b_rx_turn1", dut_o[1], V_TURN);
        step(1); chk("b_rx_idle", dut_o[1], V_IDLE);
        step(1); chk("b_tx_regrant", dut_o[1], V_TX);
        tx_r[1] = 1'b0;
        step(3); chk("b_done", dut_o[1], V_IDLE);

        // B: TX drop coincides with the hold limit -> normal release, no preempt
        tx_r[1] = 1'b1; rx_r[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1); chk($sformatf("b_sim_tx_%0d", k), dut_o[1], V_TX);
        end
        tx_r[1] = 1'b0;
        step(1); chk("b_sim_release", dut_o[1], V_TURN);
        tx_r[1] = 1'b1;
        step(1); chk("b_sim_turn1", dut_o[1], V_TURN);
        step(1); chk("b_sim_idle", dut_o[1], V_IDLE);
        step(1); chk("b_no_preempt_tx", dut_o[1], V_TX);
        tx_r[1] = 1'b0; rx_r[1] = 1'b0;
        step(3); chk("b_sim_done", dut_o[1], V_IDLE);

        // C: full 3-cycle settle, then abort in the 2nd settle cycle
        rx_r[2] = 1'b1;
        step(1); chk("c_settle0", dut_o[2], V_SET);
        step(1); chk("c_settle1", dut_o[2], V_SET);
        step(1); chk("c_settle2", dut_o[2], V_SET);
        step(1); chk("c_rx_gnt", dut_o[2], V_RX);
        rx_r[2] = 1'b0;
        step(1); chk("c_turn0", dut_o[2], V_TURN);
        step(1); chk("c_turn1", dut_o[2], V_TURN);
        step(1); chk("c_idle", dut_o[2], V_IDLE);
        rx_r[2] = 1'b1;
        step(1); chk("c_abort_s1", dut_o[2], V_SET);
        step(1); chk("c_abort_s2", dut_o[2], V_SET);
        rx_r[2] = 1'b0;
        step(1); chk("c_abort_turn0", dut_o[2], V_TURN);
        step(1); chk("c_abort_turn1", dut_o[2], V_TURN);
        step(1); chk("c_abort_idle", dut_o[2], V_IDLE);

        // D: zero guards, alternating requests with a 1-cycle gap
        tx_r[3] = 1'b1;
        step(1); chk("d_tx", dut_o[3], V_TX);
        tx_r[3] = 1'b0; rx_r[3] = 1'b1;
        step(1); chk("d_gap1", dut_o[3], V_IDLE);
        step(1); chk("d_rx_direct", dut_o[3], V_RX);
        rx_r[3] = 1'b0; tx_r[3] = 1'b1;
        step(1); chk("d_gap2", dut_o[3], V_IDLE);
        step(1); chk("d_tx_again", dut_o[3], V_TX);
        tx_r[3] = 1'b0;
        step(1); chk("d_idle", dut_o[3], V_IDLE);

        step(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
